// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; clear overrides push and pop.
module fetch_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     clear,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q];
    assign count   = cnt_q;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch: owns the PC, reads the I-cache, buffers {pc, instr} for decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            icache_ren,
    output logic [XLEN-3:0] icache_addr,
    input  logic            icache_stall,
    input  logic [XLEN-1:0] icache_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, shadow_q, shadow_d, tgt;
    logic            resp, push, pop_eff, bypass;
    logic            fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count, count_after;
    fetch_entry_t    head;

    assign icache_ren  = (state_q != IDLE);
    assign icache_addr = pc_q[XLEN-1:2];
    assign tgt         = redirect_pc & ~XLEN'(3);
    assign resp        = (state_q == REQ) && !icache_stall;
    assign pop_eff     = id_ready && !fifo_empty;
    assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop_eff);

`ifdef FETCH_BYPASS_EN
    assign bypass = resp && !redirect_valid && fifo_empty && id_ready;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        shadow_d = shadow_q;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d    = tgt;
                    state_d = REQ;
                end else if (!fifo_full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    if (icache_stall) begin
                        shadow_d = tgt;
                        state_d  = DROP;
                    end else begin
                        pc_d    = tgt;
                        state_d = IDLE;
                    end
                end else if (!icache_stall) begin
                    push    = !bypass;
                    pc_d    = pc_q + XLEN'(PC_STEP);
                    state_d = (count_after < CNT_W'(FIFO_DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                // The outstanding read cannot be aborted; wait it out and discard it.
                if (redirect_valid) shadow_d = tgt;
                if (!icache_stall) begin
                    pc_d    = redirect_valid ? tgt : shadow_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            shadow_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            shadow_q <= shadow_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ('{pc: pc_q, instr: icache_rdata}),
        .pop       (id_ready),
        .clear     (redirect_valid),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        id_valid = !fifo_empty;
        id_instr = fifo_empty ? NOP_INSTR : head.instr;
        id_pc    = fifo_empty ? '0 : head.pc;
        if (bypass) begin
            id_valid = 1'b1;
            id_instr = icache_rdata;
            id_pc    = pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: streaming, backpressure, stalls, redirects, async reset.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icache_ren;
    logic [29:0] icache_addr;
    logic        icache_stall = 1'b0;
    logic [31:0] icache_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc << 5) ^ 32'h5A00_0033;
    endfunction

    // Cache model: returns a word derived from the requested address.
    assign icache_rdata = instr_of({icache_addr, 2'b00});

    fetch_buffer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_ren     (icache_ren),
        .icache_addr    (icache_addr),
        .icache_stall   (icache_stall),
        .icache_rdata   (icache_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ren"},   {31'b0, icache_ren}, 32'd0);
        chk({tag, ".valid"}, {31'b0, id_valid},   32'd0);
        chk({tag, ".instr"}, id_instr,            NOP_INSTR);
        chk({tag, ".pc"},    id_pc,               32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        icache_stall = 1'b0;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Streaming with continuous hits
        @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        chk({"idle_ren"}, {31'b0, icache_ren}, 32'd0);
        step(1);
        chk("s1_ren",   {31'b0, icache_ren}, 32'd1);
        chk("s1_addr",  {2'b0, icache_addr}, 32'd0);
        chk("s1_valid", {31'b0, id_valid},   32'd0);
        step(1);
        chk("s2_addr",  {2'b0, icache_addr}, 32'd1);
        chk("s2_pc",    id_pc,               32'd0);
        chk("s2_instr", id_instr,            instr_of(32'd0));
        step(1);
        chk("s3_addr",  {2'b0, icache_addr}, 32'd2);
        chk("s3_pc",    id_pc,               32'd4);
        step(1);
        chk("s4_addr",  {2'b0, icache_addr}, 32'd3);
        chk("s4_pc",    id_pc,               32'd8);
        step(1);
        chk("s5_addr",  {2'b0, icache_addr}, 32'd4);
        chk("s5_pc",    id_pc,               32'd12);

        // Stall at pc 0x10 for three cycles
        icache_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("stall_ren",   {31'b0, icache_ren}, 32'd1);
            chk("stall_addr",  {2'b0, icache_addr}, 32'd4);
            chk("stall_valid", {31'b0, id_valid},   32'd0);
        end
        icache_stall = 1'b0;
        step(1);
        chk("unstall_pc",    id_pc,               32'h10);
        chk("unstall_valid", {31'b0, id_valid},   32'd1);
        chk("unstall_addr",  {2'b0, icache_addr}, 32'd5);

        // Redirect during stall at pc 0x20 (low bits of target ignored)
        step(3);
        chk("pre_drop_addr", {2'b0, icache_addr}, 32'd8);
        icache_stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        step(1);
        redirect_valid = 1'b0;
        chk("drop_valid", {31'b0, id_valid},   32'd0);
        chk("drop_addr",  {2'b0, icache_addr}, 32'd8);
        step(1);
        chk("drop_hold_ren", {31'b0, icache_ren}, 32'd1);
        icache_stall = 1'b0;
        step(1);
        chk("drop_done_ren",   {31'b0, icache_ren}, 32'd0);
        chk("drop_done_valid", {31'b0, id_valid},   32'd0);
        step(1);
        chk("redir_addr",  {2'b0, icache_addr}, 32'h40);
        chk("redir_valid", {31'b0, id_valid},   32'd0);
        step(1);
        chk("redir_pc",    id_pc,    32'h100);
        chk("redir_instr", id_instr, instr_of(32'h100));

        // Backpressure: id_ready low for five cycles
        do_reset();
        id_ready = 1'b0;
        step(5);
        chk("bp_ren",   {31'b0, icache_ren}, 32'd0);
        chk("bp_valid", {31'b0, id_valid},   32'd1);
        chk("bp_head",  id_pc,               32'd0);
        id_ready = 1'b1;
        step(1);
        chk("bp_drain1", id_pc,               32'd4);
        chk("bp_ren2",   {31'b0, icache_ren}, 32'd0);
        step(1);
        chk("bp_empty",  {31'b0, id_valid},   32'd0);
        chk("bp_resume", {2'b0, icache_addr}, 32'd2);
        step(1);
        chk("bp_pc8",    id_pc,               32'd8);

        // Redirect with a full FIFO while decode pops
        do_reset();
        id_ready = 1'b0;
        step(4);
        chk("full_ren", {31'b0, icache_ren}, 32'd0);
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        step(1);
        redirect_valid = 1'b0;
        chk("full_redir_valid", {31'b0, id_valid},   32'd0);
        chk("full_redir_addr",  {2'b0, icache_addr}, 32'h80);
        step(1);
        chk("full_redir_pc", id_pc, 32'h200);

        // Redirect on a response cycle, target wraps past the top of memory
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step(1);
        redirect_valid = 1'b0;
        chk("hit_redir_valid", {31'b0, id_valid},   32'd0);
        chk("hit_redir_ren",   {31'b0, icache_ren}, 32'd0);
        step(1);
        chk("wrap_addr0", {2'b0, icache_addr}, 32'h3FFF_FFFF);
        step(1);
        chk("wrap_pc0",   id_pc,               32'hFFFF_FFFC);
        chk("wrap_addr1", {2'b0, icache_addr}, 32'd0);
        step(1);
        chk("wrap_pc1",   id_pc,               32'd0);

        // Asynchronous reset in the middle of a stalled request
        icache_stall = 1'b1;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        icache_stall = 1'b0;
        step(1);
        chk("restart_ren",  {31'b0, icache_ren}, 32'd1);
        chk("restart_addr", {2'b0, icache_addr}, 32'd0);
        step(1);
        chk("restart_pc",   id_pc,               32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch stage directly upstream of decode and the immediate generator.
- Owns the PC, issues word reads to the instruction cache, and buffers returned words with their PCs in a small FIFO.
- Presents one {pc, instruction} pair per cycle to decode under a valid/ready handshake.
- Handles redirects (branch/jump/flush), including redirects that arrive while a cache read is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, buffer entries; power of two, minimum 2.
- XLEN, 32, PC and instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- icache_ren  out  1  read request to instruction cache.
- icache_addr  out  30  word address, equal to pc[31:2].
- icache_stall  in  1  high = response not ready; data valid in the cycle where ren=1 and stall=0.
- icache_rdata  in  32  instruction word returned by the cache.
- redirect_valid  in  1  branch/jump/flush from execute.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and treated as 0.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_valid  out  1  head entry valid.
- id_instr  out  32  instruction word to decode/immediate generation.
- id_pc  out  32  PC of id_instr.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, FIFO empty, state=IDLE.
  - icache_ren=0, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0.
- State machine:
  - IDLE: if the FIFO has a free slot counting in-flight requests (count<FIFO_DEPTH), assert ren with addr=pc[31:2] -> REQ.
  - REQ: hold ren and addr stable while icache_stall=1. On stall=0:
    - push {pc, rdata} and set pc+=4.
    - If the FIFO still has room after the push, issue the next request back-to-back (stay in REQ); otherwise go to IDLE.
  - DROP: a redirect arrived while REQ was outstanding. Keep ren/addr held (the cache protocol cannot abort). On stall=0, discard rdata, set pc=redirect target (latched in a shadow register), then go to IDLE.
- Redirect:
  - Clears the FIFO in the same edge and sets id_valid=0 from the next cycle.
  - In IDLE: pc=redirect_pc.
  - In REQ with stall=1: enter DROP.
  - In REQ with stall=0 in the same cycle: discard that response and set pc=redirect_pc.
  - A redirect while in DROP overwrites the shadow target.
- Redirect has priority over push and pop in the same cycle. A pop on that cycle is still counted as consumed by decode; decode ignores it because execute flushes.
- FIFO:
  - Push and pop in the same cycle when full is legal; count is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - id_valid = !empty; id_instr/id_pc are the head entry (registered storage, no combinational path from icache_rdata unless FETCH_BYPASS_EN).
- Latency: response accepted at edge N -> visible to decode after edge N (one cycle).
- Throughput: one instruction per cycle when the cache hits continuously and id_ready=1.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, a response arrives (stall=0, no redirect) and id_ready=1, drive id_valid/id_instr/id_pc combinationally from icache_rdata and the current pc, and skip the push. This gives zero-cycle fetch-to-decode latency.
- Undefined: all responses go through the FIFO, giving one cycle of latency.

Decomposition:
- Shared package holds:
  - fetch state enum {IDLE, REQ, DROP}.
  - NOP_INSTR = 32'h0000_0013.
  - PC_STEP = 4.
  - Typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Natural sub-module: fetch_fifo, a parameterized sync FIFO of fetch_entry_t with push, pop, clear, full, empty and count.

Test Plan:
- Reset release, cache always ready (stall=0), id_ready=1 -> addr sequence 0,1,2,3; id_pc 0,4,8,12 on consecutive cycles, one cycle after each response.
- id_ready=0 for 5 cycles -> after 2 responses ren drops, FIFO holds pc 0 and 4; on id_ready=1 these drain in order and fetch resumes at pc 8.
- icache_stall=1 for 3 cycles at pc 0x10 -> ren and addr=0x4 held constant for all 4 cycles; entry pushed only on the stall=0 cycle.
- Redirect to 0x100 during stall at pc 0x20 -> state DROP; the 0x20 data never reaches id_*; the next request addr=0x40 (word of 0x100); the first id_pc is 0x100.
- Redirect in the same cycle as a push and pop with a full FIFO -> FIFO empty next cycle, id_valid=0, pc=redirect target.
- rst_n asserted mid-REQ -> all outputs return to reset values immediately and asynchronously; after release, fetch restarts at RESET_PC.
